alu_seq_exec: RTL



---
 rtl/alu_seq_exec.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle logic/arith/compare/LUI, iterative shifts.
// Valid/ready on both the request and the result side.
module alu_seq_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [3:0]      i_alu_control,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_illegal,
  output logic            o_busy
);

  localparam int SW = $clog2(XLEN);
  localparam int RW = SW + 1;
  localparam logic [RW-1:0] STEP = RW'(SHIFT_STEP);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    K_SLL,
    K_SRL,
    K_SRA
  } kind_t;

  state_t          state;
  kind_t           kind;
  kind_t           kind_c;
  logic [XLEN-1:0] res;
  logic [XLEN-1:0] calc;
  logic [XLEN-1:0] shifted;
  logic [RW-1:0]   rem;
  logic [RW-1:0]   rem_n;
  logic [RW-1:0]   step;
  logic [SW-1:0]   shamt;
  logic            zero;
  logic            illegal;
  logic            bad;
  logic            is_shift;
  logic            accept;

  assign shamt = i_op_b[SW-1:0];

  assign o_in_ready = !i_flush &&
    (state == IDLE || (state == DONE && i_out_ready));
  assign accept = i_in_valid && o_in_ready;

  assign o_out_valid = (state == DONE);
  assign o_busy      = (state != IDLE);
  assign o_result    = res;
  assign o_zero      = zero;
  assign o_illegal   = illegal;

  always_comb begin
    calc     = '0;
    bad      = 1'b0;
    is_shift = 1'b0;
    kind_c   = K_SLL;
    unique case (i_alu_control)
      4'b0000: calc = i_op_a + i_op_b;
      4'b0001: calc = i_op_a - i_op_b;
      4'b0010: begin
        is_shift = 1'b1;
        kind_c   = K_SLL;
        calc     = i_op_a;
      end
      4'b0011: calc = XLEN'($signed(i_op_a) < $signed(i_op_b));
      4'b0100: calc = XLEN'(i_op_a < i_op_b);
      4'b0101: calc = i_op_a ^ i_op_b;
      4'b0110: begin
        is_shift = 1'b1;
        kind_c   = K_SRL;
        calc     = i_op_a;
      end
      4'b0111: begin
        is_shift = 1'b1;
        kind_c   = K_SRA;
        calc     = i_op_a;
      end
      4'b1000: calc = i_op_a | i_op_b;
      4'b1001: calc = i_op_a & i_op_b;
      4'b1010: calc = i_op_b;
      default: bad = 1'b1;
    endcase
  end

  // Each SHIFT cycle moves by at most SHIFT_STEP positions.
  always_comb begin
    step    = (rem > STEP) ? STEP : rem;
    rem_n   = rem - step;
    shifted = res;
    unique case (kind)
      K_SLL:   shifted = res << step;
      K_SRL:   shifted = res >> step;
      default: shifted = XLEN'($signed(res) >>> step);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      kind    <= K_SLL;
      res     <= '0;
      rem     <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else if (i_flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        SHIFT: begin
          res  <= shifted;
          rem  <= rem_n;
          zero <= (shifted == '0);
          if (rem_n == '0) state <= DONE;
        end
        default: begin
          if (accept) begin
            res     <= calc;
            zero    <= (calc == '0);
            illegal <= bad;
            kind    <= kind_c;
            rem     <= RW'(shamt);
            state   <= (is_shift && shamt != '0) ? SHIFT : DONE;
          end else if (state == DONE && i_out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
